player_cmd_arbiter: RTL

- Shares the 16-bit Player instruction bus between NUM_REQ requesters: enemy hit logic, item/heal logic, menu/ATK logic and the input decoder.
- Issues exactly one instruction at a time and returns the bus to NOP (16'h0000) between instructions, so the Player never applies a heal or damage twice.
- Holds movement instructions (opcode 4'b0101) until the slow movement tick samples them.
- Sits between the game FSM/requesters and Player.instruction.

---
 rtl/player_pkg.sv | 39 +++
 rtl/rr_picker.sv | 33 +++
 rtl/player_cmd_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared Player definitions: instruction opcodes, move directions, arbiter FSM states
// and the death filter that turns blocked opcodes into NOP.
package player_pkg;

   localparam logic [3:0] OP_NOP     = 4'h0;
   localparam logic [3:0] OP_HEAL    = 4'h1;
   localparam logic [3:0] OP_DMG     = 4'h2;
   localparam logic [3:0] OP_ATK_ADD = 4'h3;
   localparam logic [3:0] OP_ATK_SET = 4'h4;
   localparam logic [3:0] OP_MOVE    = 4'h5;
   localparam logic [3:0] OP_HP_SET  = 4'h6;

   localparam logic [15:0] INSTR_NOP = 16'h0000;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_RIGHT = 2'd2,
      DIR_DOWN  = 2'd3
   } move_dir_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      HOLD_MOVE,
      GAP
   } arb_state_t;

   // A dead Player may still take damage, attack-set and HP-set (revive),
   // but heals, attack boosts and moves are swallowed.
   function automatic logic [15:0] death_filter(input logic [15:0] instr, input logic dead);
      logic [3:0] op;
      op = instr[15:12];
      if (dead && (op == OP_HEAL || op == OP_ATK_ADD || op == OP_MOVE))
         return INSTR_NOP;
      return instr;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [2:0]         ptr,
   output logic [2:0]         grant,
   output logic               any
);

   logic [2:0] lo_idx;
   logic [2:0] hi_idx;
   logic       hi_any;

   // Lowest valid overall covers the wrap case; lowest valid at/after ptr wins otherwise.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      hi_any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid[i]) begin
            lo_idx = 3'(i);
            if (i >= int'(ptr)) begin
               hi_idx = 3'(i);
               hi_any = 1'b1;
            end
         end
      end
      grant = hi_any ? hi_idx : lo_idx;
      any   = |valid;
   end

endmodule

// File: rtl/player_cmd_arbiter.sv
// Arbitrates the Player instruction bus, one instruction at a time with NOP gaps.
// Define PLAYER_ARB_DAMAGE_PRIO_EN to let damage requests bypass round-robin.
module player_cmd_arbiter
   import player_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MOVE_TIMEOUT = 20000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [16*NUM_REQ-1:0]   req_instr,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    move_tick,
   input  logic                    is_death,
   output logic [15:0]             instruction,
   output logic [2:0]              grant_id,
   output logic                    busy,
   output logic                    move_timeout
);

   localparam int CW = $clog2(MOVE_TIMEOUT + 1);

   arb_state_t      state;
   logic [2:0]      ptr;
   logic [CW-1:0]   hold_cnt;
   logic [2:0]      rr_idx;
   logic [2:0]      grant_idx;
   logic [2:0]      next_ptr;
   logic            pick_any;
   logic [15:0]     sel_instr;
   logic [15:0]     filt_instr;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_rr (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (rr_idx),
      .any   (pick_any)
   );

`ifdef PLAYER_ARB_DAMAGE_PRIO_EN
   logic [2:0] dmg_idx;
   logic       dmg_any;

   always_comb begin
      dmg_idx = '0;
      dmg_any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && req_instr[16*i+12 +: 4] == OP_DMG) begin
            dmg_idx = 3'(i);
            dmg_any = 1'b1;
         end
      end
   end

   assign grant_idx = dmg_any ? dmg_idx : rr_idx;
`else
   assign grant_idx = rr_idx;
`endif

   always_comb begin
      sel_instr = INSTR_NOP;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == grant_idx)
            sel_instr = req_instr[16*i +: 16];
      end
   end

   assign filt_instr = death_filter(sel_instr, is_death);
   assign next_ptr   = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;

   // A filtered move is already NOP, so it takes the short ISSUE path instead of waiting for a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         instruction  <= INSTR_NOP;
         req_ready    <= '0;
         grant_id     <= '0;
         busy         <= 1'b0;
         move_timeout <= 1'b0;
         ptr          <= '0;
         hold_cnt     <= '0;
      end else begin
         req_ready    <= '0;
         move_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  req_ready   <= NUM_REQ'(1) << grant_idx;
                  instruction <= filt_instr;
                  grant_id    <= grant_idx;
                  ptr         <= next_ptr;
                  hold_cnt    <= '0;
                  busy        <= 1'b1;
                  state       <= (filt_instr[15:12] == OP_MOVE) ? HOLD_MOVE : ISSUE;
               end
            end
            ISSUE: begin
               instruction <= INSTR_NOP;
               state       <= GAP;
            end
            HOLD_MOVE: begin
               if (move_tick) begin
                  instruction <= INSTR_NOP;
                  state       <= GAP;
               end else if (hold_cnt == CW'(MOVE_TIMEOUT - 1)) begin
                  move_timeout <= 1'b1;
                  instruction  <= INSTR_NOP;
                  state        <= GAP;
               end else begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
